prg_loader: RTL and testbench

- Sits between the hps_io ioctl download stream and the laser500 system RAM write port.
- Parses the .VZ header of a program loaded via the OSD "Load Program" entry, then writes the payload bytes into RAM through a small FIFO using a req/ack handshake.
- Holds the CPU while loading. For BASIC programs it patches the end-of-program pointer.
- Reports the load result and program bounds to the rest of the core.

---
 rtl/prg_loader_pkg.sv | 24 ++
 rtl/prg_loader_if.sv | 27 ++
 rtl/prg_loader_fifo.sv | 60 ++++++
 rtl/prg_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prg_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prg_loader_pkg.sv
// Shared constants and state encoding for the Laser 500 program loader.
package laser500_pkg;

  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_BIN   = 8'hF1;
  localparam int         VZ_TYPE_OFS   = 21;
  localparam int         VZ_ADDR_OFS   = 22;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    DRAIN,
    PTR_LO,
    PTR_HI,
    DONE
  } loader_state_t;

  // Only BASIC and machine-code images are loadable.
  function automatic logic is_valid_type(input logic [7:0] t);
    return (t == VZ_TYPE_BASIC) || (t == VZ_TYPE_BIN);
  endfunction

endpackage

// File: rtl/prg_loader_if.sv
// Bundles the hps_io download stream and the RAM write port.
// master = loader side, slave = hps_io / RAM side.
interface prg_loader_if;

  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;

  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_req;
  logic        mem_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    output ioctl_wait, mem_addr, mem_data, mem_req
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    input  ioctl_wait, mem_addr, mem_data, mem_req
  );

endinterface

// File: rtl/prg_loader_fifo.sv
// Small show-ahead byte FIFO between the download stream and the RAM writer.
module prg_loader_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [7:0]                 i_data,
  input  logic                       i_pop,
  output logic [7:0]                 o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/prg_loader.sv
// Laser 500 .VZ program loader: parses the header, streams the payload into
// RAM through a FIFO, patches the BASIC end pointer and reports the result.
// Optional macro PRG_LOADER_CKSUM_EN adds the prg_cksum payload sum output.
module prg_loader
  import laser500_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX      = 8'd1,
  parameter int          HDR_LEN        = 24,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] BASIC_PTR_ADDR = 16'h83E9
) (
  input  logic         clk,
  input  logic         reset_n,
  prg_loader_if.master bus,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [7:0]   prg_type,
  output logic [15:0]  prg_start,
  output logic [15:0]  prg_end
`ifdef PRG_LOADER_CKSUM_EN
  ,
  output logic [15:0]  prg_cksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  loader_state_t r_state;
  loader_state_t w_next;

  logic             r_accept_d;
  logic             r_bad;
  logic             r_ptr_sent;
  logic             r_cpu_hold;
  logic             r_load_done;
  logic             r_load_err;
  logic [7:0]       r_prg_type;
  logic [15:0]      r_prg_start;
  logic [15:0]      r_count;
  logic [15:0]      r_wr_addr;
  logic             r_mem_req;
  logic [15:0]      r_mem_addr;
  logic [7:0]       r_mem_data;
`ifdef PRG_LOADER_CKSUM_EN
  logic [15:0]      r_cksum;
`endif

  logic             w_accept;
  logic             w_accept_rise;
  logic             w_byte;
  logic             w_hdr_last;
  logic             w_in_ptr;
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_push_ok;
  logic             w_push_drop;
  logic             w_issue;
  logic             w_ptr_issue;
  logic             w_acked;
  logic [15:0]      w_prg_end;
  logic [7:0]       w_fifo_data;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_accept      = bus.ioctl_download && (bus.ioctl_index == PRG_INDEX);
  assign w_accept_rise = w_accept && !r_accept_d;
  assign w_byte        = w_accept && bus.ioctl_wr;
  assign w_hdr_last    = (r_state == HEADER) && w_byte && (bus.ioctl_addr == 25'(HDR_LEN - 1));
  assign w_in_ptr      = (r_state == PTR_LO) || (r_state == PTR_HI);
  assign w_fifo_push   = (r_state == DATA) && !r_bad && w_byte && !w_accept_rise;
  assign w_push_ok     = w_fifo_push && !w_fifo_full;
  assign w_push_drop   = w_fifo_push && w_fifo_full;
  assign w_issue       = ((r_state == DATA) || (r_state == DRAIN)) && !r_mem_req &&
                         !w_fifo_empty && !w_accept_rise;
  assign w_fifo_pop    = w_issue;
  assign w_ptr_issue   = w_in_ptr && !r_mem_req && !r_ptr_sent && !w_accept_rise;
  assign w_acked       = r_mem_req && bus.mem_ack;
  assign w_prg_end     = r_prg_start + r_count;

  assign bus.ioctl_wait = (w_fifo_count >= CNT_W'(FIFO_DEPTH - 2));
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign cpu_hold       = r_cpu_hold;
  assign load_done      = r_load_done;
  assign load_err       = r_load_err;
  assign prg_type       = r_prg_type;
  assign prg_start      = r_prg_start;
  assign prg_end        = w_prg_end;
`ifdef PRG_LOADER_CKSUM_EN
  assign prg_cksum      = r_cksum;
`endif

  prg_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_accept_rise),
    .i_push  (w_fifo_push),
    .i_data  (bus.ioctl_data),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Loader state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; a fresh download edge restarts from any state.
  always_comb begin
    w_next = r_state;
    if (w_accept_rise) begin
      w_next = HEADER;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        HEADER:  if (w_hdr_last) w_next = DATA;
                 else if (!bus.ioctl_download) w_next = DONE;
        DATA:    if (!bus.ioctl_download) w_next = r_bad ? DONE : DRAIN;
        DRAIN:   if (w_fifo_empty && !r_mem_req)
                   w_next = (r_prg_type == VZ_TYPE_BASIC) ? PTR_LO : DONE;
        PTR_LO:  if (w_acked) w_next = PTR_HI;
        PTR_HI:  if (w_acked) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Header capture, payload accounting, RAM request generation and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accept_d  <= 1'b0;
      r_bad       <= 1'b0;
      r_ptr_sent  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_prg_type  <= '0;
      r_prg_start <= '0;
      r_count     <= '0;
      r_wr_addr   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
`ifdef PRG_LOADER_CKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_accept_d  <= w_accept;
      r_load_done <= 1'b0;
      if (w_accept_rise) begin
        r_cpu_hold <= 1'b1;
        r_load_err <= 1'b0;
        r_count    <= '0;
        r_bad      <= 1'b0;
        r_mem_req  <= 1'b0;
        r_ptr_sent <= 1'b0;
`ifdef PRG_LOADER_CKSUM_EN
        r_cksum    <= '0;
`endif
      end else begin
        if (r_state == HEADER) begin
          if (w_byte) begin
            if (bus.ioctl_addr == 25'(VZ_TYPE_OFS)) r_prg_type <= bus.ioctl_data;
            if (bus.ioctl_addr == 25'(VZ_ADDR_OFS)) r_prg_start[7:0] <= bus.ioctl_data;
            if (bus.ioctl_addr == 25'(VZ_ADDR_OFS + 1)) begin
              r_prg_start[15:8] <= bus.ioctl_data;
              r_wr_addr         <= {bus.ioctl_data, r_prg_start[7:0]};
            end
            if (w_hdr_last && !is_valid_type(r_prg_type)) begin
              r_bad      <= 1'b1;
              r_load_err <= 1'b1;
            end
          end else if (!bus.ioctl_download) begin
            r_load_err <= 1'b1;
          end
        end
        if (w_push_ok) begin
          r_count <= r_count + 16'd1;
`ifdef PRG_LOADER_CKSUM_EN
          r_cksum <= r_cksum + {8'h00, bus.ioctl_data};
`endif
        end
        if (w_push_drop) r_load_err <= 1'b1;
        if (w_acked) r_mem_req <= 1'b0;
        if (w_issue) begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_wr_addr;
          r_mem_data <= w_fifo_data;
          r_wr_addr  <= r_wr_addr + 16'd1;
        end
        if (w_ptr_issue) begin
          r_mem_req  <= 1'b1;
          r_ptr_sent <= 1'b1;
          r_mem_addr <= (r_state == PTR_LO) ? BASIC_PTR_ADDR : BASIC_PTR_ADDR + 16'd1;
          r_mem_data <= (r_state == PTR_LO) ? w_prg_end[7:0] : w_prg_end[15:8];
        end
        if (w_in_ptr && w_acked) r_ptr_sent <= 1'b0;
        if (r_state == DONE) begin
          r_load_done <= 1'b1;
          r_cpu_hold  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// Directed testbench for prg_loader with a simple RAM responder.
`timescale 1ns/1ps
module tb_prg_loader;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  prg_type;
  logic [15:0] prg_start;
  logic [15:0] prg_end;
`ifdef PRG_LOADER_CKSUM_EN
  logic [15:0] prg_cksum;
`endif

  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  payload [0:31];
  int          stall_cnt;
  int          done_pulses;
  bit          req_unstable;
  bit          saw_wait;
  int          wait_at;

  prg_loader_if bus();

  prg_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .prg_type  (prg_type),
    .prg_start (prg_start),
    .prg_end   (prg_end)
`ifdef PRG_LOADER_CKSUM_EN
    ,
    .prg_cksum (prg_cksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder: acks each request after stall_cnt cycles, logs writes,
  // watches request stability and counts load_done pulses.
  initial begin
    logic [15:0] pa;
    logic [7:0]  pd;
    bit          pv;
    pv = 0;
    pa = '0;
    pd = '0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) done_pulses++;
      if (bus.mem_req === 1'b1) begin
        if (pv && (bus.mem_addr !== pa || bus.mem_data !== pd)) req_unstable = 1;
        pa = bus.mem_addr;
        pd = bus.mem_data;
        pv = 1;
      end else begin
        pv = 0;
      end
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req === 1'b1) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          wr_addr_q.push_back(bus.mem_addr);
          wr_data_q.push_back(bus.mem_data);
          bus.mem_ack = 1'b1;
        end
      end
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_pulses  = 0;
    req_unstable = 0;
    saw_wait     = 0;
    wait_at      = -1;
    stall_cnt    = 0;
  endtask

  task automatic drive_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus.ioctl_wr   = 1'b0;
    @(negedge clk);
  endtask

  // Sends hdr_n header bytes then n payload bytes, honouring ioctl_wait.
  task automatic send_file(input logic [7:0] idx, input logic [7:0] typ,
                           input logic [15:0] start, input int hdr_n,
                           input int n, input bit keep_open);
    logic [7:0] hb;
    int guard;
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < hdr_n; i++) begin
      if (i == 21)      hb = typ;
      else if (i == 22) hb = start[7:0];
      else if (i == 23) hb = start[15:8];
      else              hb = 8'h41 + 8'(i);
      drive_byte(25'(i), hb);
    end
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (bus.ioctl_wait === 1'b1 && guard < 2000) begin
        if (!saw_wait) begin
          saw_wait = 1;
          wait_at  = i;
        end
        @(negedge clk);
        guard++;
      end
      total++;
      if (guard >= 2000) begin
        bad++;
        $display("[TB] FAIL ioctl_wait_timeout got=%0d cycles want<2000", guard);
      end
      drive_byte(25'(24 + i), payload[i]);
    end
    if (!keep_open) bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    seen = (load_done === 1'b1);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    settle(3);
    total++;
    if ({cpu_hold, load_done, load_err} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=000", {cpu_hold, load_done, load_err});
    end
    total++;
    if ({prg_type, prg_start, prg_end} !== 40'h0) begin
      bad++; $display("[TB] FAIL reset_regs got=%h want=0", {prg_type, prg_start, prg_end});
    end
    total++;
    if ({bus.mem_req, bus.ioctl_wait} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_bus got=%b want=00", {bus.mem_req, bus.ioctl_wait});
    end
    reset_n = 1'b1;
    settle(2);
  endtask

  task automatic test_basic_load();
    logic [15:0] ea [5];
    logic [7:0]  ed [5];
    bit seen;
    ea = '{16'h8995, 16'h8996, 16'h8997, 16'h83E9, 16'h83EA};
    ed = '{8'hAA, 8'hBB, 8'hCC, 8'h98, 8'h89};
    clear_log();
    payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
    send_file(8'd1, 8'hF0, 16'h8995, 24, 3, 0);
    total++;
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL basic_hold got=%b want=1", cpu_hold); end
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL basic_done got=0 want=1"); end
    total++;
    if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold_drop got=%b want=0", cpu_hold); end
    total++;
    if ({prg_type, prg_start, prg_end} !== {8'hF0, 16'h8995, 16'h8998}) begin
      bad++; $display("[TB] FAIL basic_bounds got=%h want=f089958998", {prg_type, prg_start, prg_end});
    end
    total++;
    if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got=%b want=0", load_err); end
    settle(5);
    total++;
    if (done_pulses !== 1) begin bad++; $display("[TB] FAIL basic_pulses got=%0d want=1", done_pulses); end
    total++;
    if (wr_addr_q.size() !== 5) begin
      bad++; $display("[TB] FAIL basic_write_count got=%0d want=5", wr_addr_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_q.size()) begin
        total++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
          bad++; $display("[TB] FAIL basic_write%0d got=%h:%h want=%h:%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_binary_wrap();
    logic [15:0] ea [4];
    bit seen;
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_log();
    for (int i = 0; i < 4; i++) payload[i] = 8'(i + 1);
    send_file(8'd1, 8'hF1, 16'hFFFE, 24, 4, 0);
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL bin_done got=0 want=1"); end
    total++;
    if (prg_end !== 16'h0002) begin bad++; $display("[TB] FAIL bin_end got=%h want=0002", prg_end); end
    settle(5);
    total++;
    if (wr_addr_q.size() !== 4) begin
      bad++; $display("[TB] FAIL bin_write_count got=%0d want=4", wr_addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        total++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== 8'(i + 1)) begin
          bad++; $display("[TB] FAIL bin_write%0d got=%h:%h want=%h:%h", i, wr_addr_q[i], wr_data_q[i], ea[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int errs;
    clear_log();
    stall_cnt = 30;
    for (int i = 0; i < 16; i++) payload[i] = 8'h30 + 8'(i * 3);
    send_file(8'd1, 8'hF1, 16'h9000, 24, 16, 0);
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL bp_done got=0 want=1"); end
    total++;
    if (wait_at !== 7) begin bad++; $display("[TB] FAIL bp_wait_point got=%0d want=7", wait_at); end
    total++;
    if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL bp_err got=%b want=0", load_err); end
    total++;
    if (req_unstable !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_stable got=%b want=0", req_unstable); end
    settle(5);
    total++;
    if (wr_addr_q.size() !== 16) begin
      bad++; $display("[TB] FAIL bp_write_count got=%0d want=16", wr_addr_q.size());
    end
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr_q.size()) begin
        if (wr_addr_q[i] !== 16'h9000 + 16'(i) || wr_data_q[i] !== 8'h30 + 8'(i * 3)) errs++;
      end
    end
    total++;
    if (errs !== 0) begin bad++; $display("[TB] FAIL bp_order got=%0d wrong want=0", errs); end
  endtask

  task automatic test_bad_type();
    bit seen;
    clear_log();
    for (int i = 0; i < 10; i++) payload[i] = 8'h70 + 8'(i);
    send_file(8'd1, 8'h55, 16'hA000, 24, 10, 0);
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL badtype_done got=0 want=1"); end
    total++;
    if (load_err !== 1'b1) begin bad++; $display("[TB] FAIL badtype_err got=%b want=1", load_err); end
    settle(5);
    total++;
    if (wr_addr_q.size() !== 0 || done_pulses !== 1) begin
      bad++; $display("[TB] FAIL badtype_activity got=%0d writes %0d pulses want=0 writes 1 pulse", wr_addr_q.size(), done_pulses);
    end
    clear_log();
    payload[0] = 8'h11; payload[1] = 8'h22;
    send_file(8'd1, 8'hF1, 16'h4000, 24, 2, 0);
    wait_done(seen);
    total++;
    if (!seen || load_err !== 1'b0) begin
      bad++; $display("[TB] FAIL badtype_recover got=done%b err%b want=done1 err0", seen, load_err);
    end
    settle(5);
    total++;
    if (wr_addr_q.size() !== 2) begin bad++; $display("[TB] FAIL badtype_recover_writes got=%0d want=2", wr_addr_q.size()); end
  endtask

  task automatic test_short_file();
    bit seen;
    clear_log();
    send_file(8'd1, 8'hF1, 16'h5000, 10, 0, 0);
    wait_done(seen);
    total++;
    if (!seen || load_err !== 1'b1) begin
      bad++; $display("[TB] FAIL short_result got=done%b err%b want=done1 err1", seen, load_err);
    end
    settle(5);
    total++;
    if (wr_addr_q.size() !== 0) begin bad++; $display("[TB] FAIL short_writes got=%0d want=0", wr_addr_q.size()); end
  endtask

  task automatic test_reset_midload();
    clear_log();
    stall_cnt = 1000;
    for (int i = 0; i < 5; i++) payload[i] = 8'hC0 + 8'(i);
    send_file(8'd1, 8'hF0, 16'h8000, 24, 5, 1);
    total++;
    if ({cpu_hold, bus.mem_req} !== 2'b11) begin
      bad++; $display("[TB] FAIL midload_active got=%b want=11", {cpu_hold, bus.mem_req});
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({cpu_hold, load_done, load_err, bus.mem_req, bus.ioctl_wait} !== 5'b0) begin
      bad++; $display("[TB] FAIL midload_reset_flags got=%b want=00000", {cpu_hold, load_done, load_err, bus.mem_req, bus.ioctl_wait});
    end
    total++;
    if ({prg_type, prg_start, prg_end} !== 40'h0) begin
      bad++; $display("[TB] FAIL midload_reset_regs got=%h want=0", {prg_type, prg_start, prg_end});
    end
    bus.ioctl_download = 1'b0;
    stall_cnt = 0;
    settle(3);
    reset_n = 1'b1;
    settle(10);
    total++;
    if (wr_addr_q.size() !== 0 || bus.mem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL midload_no_writes got=%0d writes req%b want=0 writes req0", wr_addr_q.size(), bus.mem_req);
    end
  endtask

  task automatic test_foreign_index();
    clear_log();
    for (int i = 0; i < 4; i++) payload[i] = 8'hE0 + 8'(i);
    send_file(8'd0, 8'hF1, 16'h6000, 24, 4, 1);
    total++;
    if ({cpu_hold, bus.ioctl_wait} !== 2'b00) begin
      bad++; $display("[TB] FAIL foreign_hold got=%b want=00", {cpu_hold, bus.ioctl_wait});
    end
    bus.ioctl_download = 1'b0;
    settle(20);
    total++;
    if (wr_addr_q.size() !== 0 || done_pulses !== 0 || prg_start !== 16'h0) begin
      bad++; $display("[TB] FAIL foreign_activity got=%0d writes %0d pulses start=%h want=0 0 0000", wr_addr_q.size(), done_pulses, prg_start);
    end
  endtask

`ifdef PRG_LOADER_CKSUM_EN
  task automatic test_cksum();
    bit seen;
    clear_log();
    payload[0] = 8'hFF; payload[1] = 8'hFF; payload[2] = 8'h02;
    send_file(8'd1, 8'hF1, 16'h7000, 24, 3, 0);
    wait_done(seen);
    total++;
    if (!seen || prg_cksum !== 16'h0200) begin
      bad++; $display("[TB] FAIL cksum got=done%b sum=%h want=done1 sum=0200", seen, prg_cksum);
    end
  endtask
`endif

  // Runs every scenario in order and prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_data     = '0;
    clear_log();
    test_reset();
    test_basic_load();
    test_binary_wrap();
    test_backpressure();
    test_bad_type();
    test_short_file();
    test_reset_midload();
    test_foreign_index();
`ifdef PRG_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
